// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and defaults for the main-memory responder.
//   word_t              : 16-bit memory word
//   MEM_LATENCY_DEFAULT : default read latency in cycles
//   rd_stage_t          : one read-pipeline stage {valid, data}
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef logic [15:0] word_t;

    localparam int MEM_LATENCY_DEFAULT = 4;

    typedef struct packed {
        logic  valid;
        word_t data;
    } rd_stage_t;

endpackage : mem_pkg

// File: rtl/mem_read_pipe.sv
// ---------------------------------------------------------------------------
// mem_read_pipe
// LATENCY-stage shift register carrying read results toward the output.
// Every stage is cleared asynchronously, so in-flight reads are dropped the
// moment reset asserts.
// Ports:
//   clk       in  : clock, rising edge
//   rst_n     in  : asynchronous active-low clear of all stages
//   in_stage  in  : entry for this cycle (valid=0 for non-read cycles)
//   out_stage out : last stage, registered
//   any_valid out : OR of every stage valid bit (reads in flight)
// ---------------------------------------------------------------------------
module mem_read_pipe
    import mem_pkg::*;
#(
    parameter int LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    input  rd_stage_t in_stage,
    output rd_stage_t out_stage,
    output logic      any_valid
);

    rd_stage_t stage_q [LATENCY];
    rd_stage_t stage_d [LATENCY];

    always_comb begin
        stage_d[0] = in_stage;
        for (int i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            any_valid = any_valid | stage_q[i].valid;
        end
    end

    assign out_stage = stage_q[LATENCY-1];

endmodule : mem_read_pipe

// File: rtl/mainmem_responder.sv
// ---------------------------------------------------------------------------
// mainmem_responder
// Word-addressed main memory behind the cache arbiter. One request per cycle;
// reads return after a fixed LATENCY through a shift pipeline, writes commit
// in one cycle with no response.
// Ports:
//   clk        in  : clock, rising edge
//   rst_n      in  : asynchronous active-low reset (storage is not reset)
//   enable     in  : request valid this cycle
//   wr         in  : 1 = write, 0 = read
//   addr       in  : byte address; word index is addr[ADDR_W-1:1]
//   data_in    in  : write data
//   data_out   out : read data, 0 when data_valid is low
//   data_valid out : one-cycle strobe per completed read
//   idle       out : no read in flight and enable low (combinational on enable)
// Parameters: ADDR_W (2..16) byte-address width, LATENCY (2..8) read latency.
// ---------------------------------------------------------------------------
module mainmem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        idle
);

    localparam int DEPTH = 2 ** (ADDR_W - 1);

    logic [ADDR_W-2:0] word_idx;
    logic              wr_en;
    logic              any_valid;
    rd_stage_t         rd_in;
    rd_stage_t         rd_out;
    word_t             mem_q [DEPTH];

    assign word_idx = addr[ADDR_W-1:1];

    // Byte-lane bit and address bits above ADDR_W-1 are deliberately ignored.
    logic unused_addr;
    if (ADDR_W < 16) begin : g_addr_trunc
        assign unused_addr = ^{addr[0], addr[15:ADDR_W]};
    end else begin : g_addr_full
        assign unused_addr = addr[0];
    end

    // Requests seen while reset is low must not disturb the array.
    assign wr_en = rst_n & enable & wr;

    // Storage has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[word_idx] <= data_in;
        end
    end

    // The word is captured at issue, so a later write to the same word
    // cannot change a read already in flight. Non-read cycles push a zeroed
    // entry so data_out is 0 whenever data_valid is low.
    always_comb begin
        rd_in = '0;
        if (enable && !wr) begin
            rd_in.valid = 1'b1;
            rd_in.data  = mem_q[word_idx];
        end
    end

    mem_read_pipe #(
        .LATENCY (LATENCY)
    ) u_read_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_stage  (rd_in),
        .out_stage (rd_out),
        .any_valid (any_valid)
    );

    assign data_valid = rd_out.valid;
    assign data_out   = rd_out.data;
    assign idle       = ~enable & ~any_valid;

endmodule : mainmem_responder

// File: tb/tb_mainmem_responder.sv
// ---------------------------------------------------------------------------
// tb_mainmem_responder
// Bench for mainmem_responder (LATENCY=4). A reference model keeps a word
// array and a queue of expected per-cycle outputs; hand-written tables and
// sequences cover the listed corner cases, and a second instance with
// ADDR_W=8 covers upper-bit aliasing.
// ---------------------------------------------------------------------------
module tb_mainmem_responder;

    localparam int LAT = 4;

    typedef struct {
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        exp_v;
        logic [15:0] exp_d;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, wr;
    logic [15:0] addr, data_in, data_out;
    logic        data_valid, idle;

    logic        enable8, wr8;
    logic [15:0] addr8, data_in8, data_out8;
    logic        data_valid8, idle8;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem_m [32768];
    logic [16:0] exp_q [$];
    logic        obs_valid;
    logic [15:0] obs_data;
    vec_t        tbl [$];

    always #5 clk = ~clk;

    mainmem_responder #(.ADDR_W(16), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(data_out), .data_valid(data_valid), .idle(idle)
    );

    mainmem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut8 (
        .clk(clk), .rst_n(rst_n), .enable(enable8), .wr(wr8), .addr(addr8),
        .data_in(data_in8), .data_out(data_out8), .data_valid(data_valid8), .idle(idle8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model_pipe();
        exp_q = {};
        for (int i = 0; i < LAT; i++) exp_q.push_back(17'h0);
    endtask

    // One bus cycle: drive at cycle start, check mid-cycle, model the edge.
    task automatic drive_cycle(input logic en, input logic w,
                               input logic [15:0] a, input logic [15:0] d);
        logic [16:0] cur;
        logic        busy;
        enable = en; wr = w; addr = a; data_in = d;
        @(negedge clk);
        cur  = exp_q.pop_front();
        busy = cur[16];
        foreach (exp_q[i]) busy = busy | exp_q[i][16];
        obs_valid = data_valid;
        obs_data  = data_out;
        check("data_valid", {31'b0, data_valid}, {31'b0, cur[16]});
        check("data_out", {16'b0, data_out}, {16'b0, cur[15:0]});
        check("idle", {31'b0, idle}, {31'b0, ~en & ~busy});
        if (rst_n && en && !w) exp_q.push_back({1'b1, mem_m[a[15:1]]});
        else                   exp_q.push_back(17'h0);
        if (rst_n && en && w) mem_m[a[15:1]] = d;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic en, input logic w, input logic [15:0] a,
                                input logic [15:0] d, input logic ev, input logic [15:0] ed);
        vec_t v;
        v.en = en; v.wr = w; v.addr = a; v.din = d; v.exp_v = ev; v.exp_d = ed;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int strobes;
        rst_n = 1'b0; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        enable8 = 1'b0; wr8 = 1'b0; addr8 = '0; data_in8 = '0;
        clear_model_pipe();

        // Reset then idle
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 16'h0, 16'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, 16'h0, 16'h0);

        // Single read latency, then write-after-read ordering
        tbl.push_back(mk(1, 1, 16'h0010, 16'hBEEF, 0, 16'h0));
        tbl.push_back(mk(1, 0, 16'h0010, 16'h0000, 0, 16'h0));
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0));
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0));
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0));
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF));
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0));
        tbl.push_back(mk(1, 1, 16'h0020, 16'h1111, 0, 16'h0));
        tbl.push_back(mk(1, 0, 16'h0020, 16'h0000, 0, 16'h0));
        tbl.push_back(mk(1, 1, 16'h0020, 16'h2222, 0, 16'h0));
        tbl.push_back(mk(1, 0, 16'h0020, 16'h0000, 0, 16'h0));
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0));
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 16'h1111));
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0));
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 16'h2222));
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0));
        foreach (tbl[i]) begin
            drive_cycle(tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].din);
            check("tbl_valid", {31'b0, obs_valid}, {31'b0, tbl[i].exp_v});
            check("tbl_data", {16'b0, obs_data}, {16'b0, tbl[i].exp_d});
        end

        // Burst fill: strobes in cycles 4..11 carry 0x1000..0x1007
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b1, 16'(2 * i), 16'(16'h1000 + i));
        for (int c = 0; c < 12; c++) begin
            if (c < 8) drive_cycle(1'b1, 1'b0, 16'(2 * c), 16'h0);
            else       drive_cycle(1'b0, 1'b0, 16'h0, 16'h0);
            if (c >= 4) begin
                check("burst_valid", {31'b0, obs_valid}, 32'd1);
                check("burst_data", {16'b0, obs_data}, 32'(16'h1000 + c - 4));
            end else begin
                check("burst_quiet", {31'b0, obs_valid}, 32'd0);
            end
        end

        // Reset mid-flight, asserted while the first strobe is on the output;
        // a write offered during reset must be ignored.
        for (int c = 0; c < 4; c++) drive_cycle(1'b1, 1'b0, 16'(2 * c), 16'h0);
        rst_n = 1'b0;
        clear_model_pipe();
        strobes = 0;
        drive_cycle(1'b1, 1'b1, 16'h0000, 16'hDEAD);
        strobes += int'(obs_valid);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive_cycle(1'b0, 1'b0, 16'h0, 16'h0);
            strobes += int'(obs_valid);
        end
        check("reset_drop_strobes", 32'(strobes), 32'd0);
        drive_cycle(1'b1, 1'b0, 16'h0000, 16'h0);
        for (int c = 0; c < LAT; c++) drive_cycle(1'b0, 1'b0, 16'h0, 16'h0);
        check("retained_valid", {31'b0, obs_valid}, 32'd1);
        check("retained_data", {16'b0, obs_data}, 32'h1000);

        // Address aliasing on the full-width instance (bit 0 ignored)
        drive_cycle(1'b1, 1'b1, 16'h0003, 16'hA5A5);
        drive_cycle(1'b1, 1'b0, 16'h0002, 16'h0);
        for (int c = 0; c < LAT; c++) drive_cycle(1'b0, 1'b0, 16'h0, 16'h0);
        check("alias_lsb_data", {16'b0, obs_data}, 32'hA5A5);

        // Randomized traffic over a preloaded window
        for (int i = 0; i < 32; i++) drive_cycle(1'b1, 1'b1, 16'(2 * i), 16'($urandom));
        for (int n = 0; n < 400; n++) begin
            logic        en_r, wr_r;
            logic [15:0] a_r;
            en_r = ($urandom_range(0, 3) != 0);
            wr_r = ($urandom_range(0, 2) == 0);
            a_r  = 16'(($urandom_range(0, 31) << 1) | $urandom_range(0, 1));
            drive_cycle(en_r, wr_r, a_r, 16'($urandom));
        end
        for (int c = 0; c < LAT + 1; c++) drive_cycle(1'b0, 1'b0, 16'h0, 16'h0);

        // Upper address bits alias on the ADDR_W=8 instance
        enable8 = 1'b1; wr8 = 1'b1; addr8 = 16'h0003; data_in8 = 16'hA5A5;
        @(posedge clk); #1;
        enable8 = 1'b1; wr8 = 1'b0; addr8 = 16'h0102; data_in8 = 16'h0;
        @(posedge clk); #1;
        enable8 = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            @(negedge clk);
            check("alias8_early", {31'b0, data_valid8}, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("alias8_valid", {31'b0, data_valid8}, 32'd1);
        check("alias8_data", {16'b0, data_out8}, 32'hA5A5);
        @(posedge clk); #1;
        @(negedge clk);
        check("alias8_single", {31'b0, data_valid8}, 32'd0);
        check("alias8_idle", {31'b0, idle8}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mainmem_responder

// File: doc/mainmem_responder.md
# mainmem_responder

Word-addressed, multi-cycle main-memory responder sitting at the far end of the cache arbiter's `mainmem_*` interface. It accepts at most one read or write request per cycle from the arbiter. Reads are fully pipelined with a fixed latency, so the arbiter can stream back-to-back block-fill reads and get one word per cycle after the initial latency. Writes commit in a single cycle and produce no response.

## Interface
Parameters:
- `ADDR_W`, 16 — byte-address width; storage depth is 2^(ADDR_W-1) 16-bit words.
- `LATENCY`, 4 — read latency in cycles; legal range 2..8.

Ports:
- `clk`  in  1 — single clock; all state updates on rising edge.
- `rst_n`  in  1 — asynchronous active-low reset.
- `enable`  in  1 — request valid this cycle.
- `wr`  in  1 — 1 means write, 0 means read; qualified by `enable`.
- `addr`  in  16 — byte address; bit 0 and bits above `ADDR_W-1` are ignored.
- `data_in`  in  16 — write data; qualified by `enable & wr`.
- `data_out`  out  16 — read data; qualified by `data_valid`, 16'h0000 otherwise.
- `data_valid`  out  1 — one-cycle strobe per completed read.
- `idle`  out  1 — no read in flight and `enable` low.

## Operation
- Word index is `addr[ADDR_W-1:1]`.
- Storage array is not reset; its contents persist across `rst_n`.
- **Read** (`enable & ~wr` in cycle N):
  - The array is sampled at the end of cycle N.
  - The word plus a valid bit enter a `LATENCY`-deep shift pipeline.
  - `data_valid`=1 and `data_out`=word during cycle N+LATENCY, for exactly one cycle.
- **Write** (`enable & wr` in cycle N): the array updates at the end of cycle N. No pipeline entry, no `data_valid`.
- **Back-to-back reads** in cycles N..N+k produce valid strobes in cycles N+LATENCY..N+LATENCY+k, in order, with no bubbles.
- **Read-after-write**, same word:
  - Write in N, read in N+1: the read returns the new data.
- **Write-after-read**, same word:
  - Read in N, write in N+1..N+LATENCY-1: the read returns the old data, because the value is captured at issue.
- **Mixed stream**: a write in a cycle leaves a bubble in the response stream at the corresponding slot.
- `idle` = `~enable & ~(|pipeline_valid)`. This is combinational on `enable`.
- **Reset** (asynchronous, any time):
  - All pipeline valid bits clear immediately; in-flight reads are dropped and never produce a strobe.
  - Pipeline data registers clear to 0.
  - `data_valid`=0, `data_out`=0, and `idle`=~`enable` while `rst_n` is low.
  - Requests presented while `rst_n` is low are ignored, including writes; the array is unchanged.

## Timing
- Reset values: `data_valid`=0, `data_out`=16'h0000. `idle` follows `~enable` only.
- `data_out` and `data_valid` come straight from the last pipeline stage, with no combinational path from inputs.
- Throughput is one request per cycle, sustained indefinitely. There is no backpressure; the arbiter must consume each strobe in the cycle it appears.
- Write-to-read visibility: 1 cycle.

## Structure
- Shared package `mem_pkg`:
  - `word_t` (16-bit).
  - `MEM_LATENCY_DEFAULT = 4`.
  - `rd_stage_t` struct {valid, data}.
- Sub-module `mem_read_pipe`:
  - Parameterised `LATENCY`-stage shift register of `rd_stage_t`.
  - Asynchronous clear on `rst_n`.
  - Exposes the last stage and an any-valid flag.
- Top level holds the storage array, write port, read sample, and the `idle` logic.

## Test plan
- **Reset then idle:** hold `rst_n`=0 for 3 cycles with `enable`=0, then release. Required: `data_valid`=0, `data_out`=0, `idle`=1 throughout.
- **Single read latency:** write 16'hBEEF to addr 16'h0010 in cycle 0, read addr 16'h0010 in cycle 1. Required: `data_valid`=1 with `data_out`=16'hBEEF in cycle 5 only.
- **Burst fill:** preload words 0..7 with 16'h1000+i; issue 8 consecutive reads at addr 16'h0000..16'h000E. Required: strobes in cycles 4..11 carrying 16'h1000..16'h1007 in order.
- **Write-after-read ordering:** word 16'h0020 holds 16'h1111. Read it in cycle 0, write 16'h2222 to it in cycle 1, read it in cycle 2. Required: cycle 4 returns 16'h1111, cycle 6 returns 16'h2222.
- **Reset mid-flight:** issue reads in cycles 0..2, assert `rst_n`=0 in cycle 3, release in cycle 4. Required: no `data_valid` at any point, and the array contents are retained on a later read.
- **Address aliasing:** write 16'hA5A5 to addr 16'h0003. Required: reading 16'h0002 returns 16'hA5A5; with `ADDR_W`=8, reading 16'h0102 also returns it.
